// File: rtl/bsg_mem_1r1w_sync_mask_write_gran_if.sv
// Port bundle for bsg_mem_1r1w_sync_mask_write_gran: write port, read request and read response.
// The memory connects through the slave modport; its user drives the master modport.
interface bsg_mem_1r1w_sync_mask_write_gran_if #(
    parameter int width_p      = 32,
    parameter int mask_width_p = 4,
    parameter int addr_width_p = 3
);
    logic                    w_v_i;
    logic [mask_width_p-1:0] w_mask_i;
    logic [addr_width_p-1:0] w_addr_i;
    logic [width_p-1:0]      w_data_i;
    logic                    r_v_i;
    logic [addr_width_p-1:0] r_addr_i;
    logic                    r_v_o;
    logic [width_p-1:0]      r_data_o;

    modport slave (
        input  w_v_i, w_mask_i, w_addr_i, w_data_i, r_v_i, r_addr_i,
        output r_v_o, r_data_o
    );

    modport master (
        output w_v_i, w_mask_i, w_addr_i, w_data_i, r_v_i, r_addr_i,
        input  r_v_o, r_data_o
    );
endinterface

// File: rtl/bsg_mem_1r1w_sync_mask_write_gran.sv
// 1R1W synchronous flop RAM with configurable write-mask granularity and per-granule written bits.
// Define BSG_MEM_1R1W_SYNC_MASK_BYPASS_EN for write-first collisions; read-first otherwise.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

module bsg_mem_1r1w_sync_mask_write_gran #(
    parameter int width_p           = 32,
    parameter int els_p             = 8,
    parameter int mask_width_p      = width_p >> 3,
    parameter int latch_last_read_p = 0,
    parameter int addr_width_lp     = `BSG_SAFE_CLOG2(els_p)
) (
    input  logic clk_i,
    input  logic reset_i,
    bsg_mem_1r1w_sync_mask_write_gran_if.slave mem_if
);

    localparam int gran_lp = width_p / mask_width_p;

    logic [width_p-1:0]      data_q    [els_p];
    logic [mask_width_p-1:0] written_q [els_p];

    logic [width_p-1:0] r_data_q, r_data_d;
    logic               r_v_q, r_v_d;

    logic [addr_width_lp:0]   els_ext;
    logic                     w_in_range, r_in_range, w_en;
    logic [addr_width_lp-1:0] w_idx, r_idx;
    logic [width_p-1:0]       rd_word;
    logic [mask_width_p-1:0]  rd_written;

    // Out-of-range indices are clamped so the arrays are never indexed past els_p;
    // the range flags below keep the clamped entry from being touched.
    always_comb begin
        els_ext    = (addr_width_lp + 1)'(els_p);
        w_in_range = {1'b0, mem_if.w_addr_i} < els_ext;
        r_in_range = {1'b0, mem_if.r_addr_i} < els_ext;
        w_idx      = w_in_range ? mem_if.w_addr_i : '0;
        r_idx      = r_in_range ? mem_if.r_addr_i : '0;
        w_en       = mem_if.w_v_i & ~reset_i & w_in_range;
        rd_word    = data_q[r_idx];
        rd_written = written_q[r_idx];
    end

    always_ff @(posedge clk_i) begin
        if (w_en) begin
            for (int unsigned k = 0; k < mask_width_p; k++) begin
                if (mem_if.w_mask_i[k]) begin
                    data_q[w_idx][k*gran_lp +: gran_lp] <= mem_if.w_data_i[k*gran_lp +: gran_lp];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            written_q <= '{default: '0};
        end else if (w_en) begin
            written_q[w_idx] <= written_q[w_idx] | mem_if.w_mask_i;
        end
    end

`ifdef BSG_MEM_1R1W_SYNC_MASK_BYPASS_EN
    logic collide;
    assign collide = w_en & r_in_range & (mem_if.w_addr_i == mem_if.r_addr_i);
`endif

    always_comb begin
        r_v_d    = mem_if.r_v_i;
        r_data_d = (latch_last_read_p != 0) ? r_data_q : '0;
        if (mem_if.r_v_i) begin
            r_data_d = '0;
            if (r_in_range) begin
                for (int unsigned k = 0; k < mask_width_p; k++) begin
`ifdef BSG_MEM_1R1W_SYNC_MASK_BYPASS_EN
                    if (collide && mem_if.w_mask_i[k]) begin
                        r_data_d[k*gran_lp +: gran_lp] = mem_if.w_data_i[k*gran_lp +: gran_lp];
                    end else if (rd_written[k]) begin
                        r_data_d[k*gran_lp +: gran_lp] = rd_word[k*gran_lp +: gran_lp];
                    end
`else
                    if (rd_written[k]) begin
                        r_data_d[k*gran_lp +: gran_lp] = rd_word[k*gran_lp +: gran_lp];
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_v_q    <= 1'b0;
            r_data_q <= '0;
        end else begin
            r_v_q    <= r_v_d;
            r_data_q <= r_data_d;
        end
    end

    assign mem_if.r_v_o    = r_v_q;
    assign mem_if.r_data_o = r_data_q;

endmodule

// File: tb/tb_bsg_mem_1r1w_sync_mask_write_gran.sv
// Directed bench: dut0 (8 entries, latched reads) and dut1 (6 entries, non-latched reads)
// receive identical stimulus; expected values are hand-computed constants.
module tb_bsg_mem_1r1w_sync_mask_write_gran;

    logic        clk;
    logic        reset;
    logic        w_v;
    logic [3:0]  w_mask;
    logic [2:0]  w_addr;
    logic [31:0] w_data;
    logic        r_v;
    logic [2:0]  r_addr;

    int total = 0;
    int bad   = 0;

`ifdef BSG_MEM_1R1W_SYNC_MASK_BYPASS_EN
    localparam logic [31:0] COLL_EXP = 32'h0102BEEF;
`else
    localparam logic [31:0] COLL_EXP = 32'h01020304;
`endif

    bsg_mem_1r1w_sync_mask_write_gran_if #(.width_p(32), .mask_width_p(4), .addr_width_p(3)) if0 ();
    bsg_mem_1r1w_sync_mask_write_gran_if #(.width_p(32), .mask_width_p(4), .addr_width_p(3)) if1 ();

    assign if0.w_v_i = w_v;    assign if1.w_v_i = w_v;
    assign if0.w_mask_i = w_mask; assign if1.w_mask_i = w_mask;
    assign if0.w_addr_i = w_addr; assign if1.w_addr_i = w_addr;
    assign if0.w_data_i = w_data; assign if1.w_data_i = w_data;
    assign if0.r_v_i = r_v;    assign if1.r_v_i = r_v;
    assign if0.r_addr_i = r_addr; assign if1.r_addr_i = r_addr;

    bsg_mem_1r1w_sync_mask_write_gran #(
        .width_p(32), .els_p(8), .mask_width_p(4), .latch_last_read_p(1)
    ) dut0 (
        .clk_i(clk), .reset_i(reset), .mem_if(if0)
    );

    bsg_mem_1r1w_sync_mask_write_gran #(
        .width_p(32), .els_p(6), .mask_width_p(4), .latch_last_read_p(0)
    ) dut1 (
        .clk_i(clk), .reset_i(reset), .mem_if(if1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic set_w(input logic v, input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
        w_v = v; w_addr = a; w_data = d; w_mask = m;
    endtask

    task automatic set_r(input logic v, input logic [2:0] a);
        r_v = v; r_addr = a;
    endtask

    task automatic check_both(input string tag, input logic rv, input logic [31:0] d0, input logic [31:0] d1);
        check({tag, "_rv0"}, {31'b0, if0.r_v_o}, {31'b0, rv});
        check({tag, "_d0"},  if0.r_data_o, d0);
        check({tag, "_rv1"}, {31'b0, if1.r_v_o}, {31'b0, rv});
        check({tag, "_d1"},  if1.r_data_o, d1);
    endtask

    initial begin
        reset = 1'b1;
        set_w(1'b0, 3'd0, 32'h0, 4'h0);
        set_r(1'b0, 3'd0);
        @(posedge clk);
        tick();
        check_both("reset", 1'b0, 32'h0, 32'h0);
        reset = 1'b0;

        set_r(1'b1, 3'd3); tick();
        check_both("rd3_after_reset", 1'b1, 32'h0, 32'h0);

        set_r(1'b0, 3'd0); set_w(1'b1, 3'd2, 32'hAABBCCDD, 4'b0101); tick();
        check_both("wr2_idle", 1'b0, 32'h0, 32'h0);

        set_w(1'b0, 3'd0, 32'h0, 4'h0); set_r(1'b1, 3'd2); tick();
        check_both("rd2_a", 1'b1, 32'h00BB00DD, 32'h00BB00DD);

        set_r(1'b0, 3'd0); set_w(1'b1, 3'd2, 32'h11223344, 4'b1000); tick();
        check_both("wr2_b_idle", 1'b0, 32'h00BB00DD, 32'h0);

        set_w(1'b0, 3'd0, 32'h0, 4'h0); set_r(1'b1, 3'd2); tick();
        check_both("rd2_b", 1'b1, 32'h11BB00DD, 32'h11BB00DD);

        // mask 0 must not alter entry 2
        set_r(1'b0, 3'd0); set_w(1'b1, 3'd2, 32'h00000000, 4'b0000); tick();
        set_w(1'b1, 3'd5, 32'h01020304, 4'b1111); tick();

        set_w(1'b1, 3'd5, 32'hDEADBEEF, 4'b0011); set_r(1'b1, 3'd5); tick();
        check_both("collide5", 1'b1, COLL_EXP, COLL_EXP);

        set_w(1'b0, 3'd0, 32'h0, 4'h0); set_r(1'b1, 3'd5); tick();
        check_both("rd5_after", 1'b1, 32'h0102BEEF, 32'h0102BEEF);

        set_r(1'b1, 3'd2); tick();
        check_both("rd2_mask0", 1'b1, 32'h11BB00DD, 32'h11BB00DD);

        set_r(1'b0, 3'd0); tick();
        check_both("idle1", 1'b0, 32'h11BB00DD, 32'h0);
        tick();
        check_both("idle2", 1'b0, 32'h11BB00DD, 32'h0);

        set_w(1'b1, 3'd4, 32'hCAFEF00D, 4'b1111); tick();
        set_w(1'b0, 3'd0, 32'h0, 4'h0); set_r(1'b1, 3'd4); tick();
        check_both("rd4_pre_reset", 1'b1, 32'hCAFEF00D, 32'hCAFEF00D);

        // mid-cycle reset pulse with a write pending across the next edge
        set_r(1'b0, 3'd0); set_w(1'b1, 3'd4, 32'h55555555, 4'b1111);
        #3 reset = 1'b1;
        #1 check_both("async_reset", 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        set_w(1'b0, 3'd0, 32'h0, 4'h0);

        set_r(1'b1, 3'd4); tick();
        check_both("rd4_post_reset", 1'b1, 32'h0, 32'h0);
        set_r(1'b1, 3'd2); tick();
        check_both("rd2_post_reset", 1'b1, 32'h0, 32'h0);

        set_r(1'b0, 3'd0); set_w(1'b1, 3'd7, 32'hFFFFFFFF, 4'b1111); tick();
        set_w(1'b0, 3'd0, 32'h0, 4'h0); set_r(1'b1, 3'd7); tick();
        check_both("rd7", 1'b1, 32'hFFFFFFFF, 32'h0);

        for (int a = 0; a < 6; a++) begin
            set_r(1'b1, 3'(a)); tick();
            check_both($sformatf("rd%0d_oor_scan", a), 1'b1, 32'h0, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
